rs_pool: RTL and testbench
==========================

Name: rs_pool

Overview:
- Parametrised reservation-station pool that replaces fixed six-entry, per-entry-FU stations with a shared pool of NUM_ENTRIES entries.
- Each entry is tagged with an FU type at dispatch.
- Sits between dispatch (stage_dp / map table / ROB) and the FU bank, listening on NUM_CDB broadcast buses.
- Issues at most one ready instruction per FU type per cycle with a valid/ready handshake, and frees the entry on issue rather than on CDB completion.

Parameters:
- NUM_ENTRIES, 8: pool depth (>=2).
- NUM_FU_TYPES, 4: FU classes (ALU, LOAD, STORE, MULT ...); type index 0..NUM_FU_TYPES-1.
- NUM_CDB, 2: CDB broadcast ports.
- ROB_TAG_W, 5: ROB tag width.
- DATA_W, 32: operand width.
- PAYLOAD_W, 64: opaque decoded-instruction bits carried to the FU.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all entries.
- squash  in  1  synchronous flush of all entries (same effect as reset).
- dp_valid  in  1  dispatch request.
- dp_ready  out  1  pool can accept this cycle.
- dp_fu_type  in  $clog2(NUM_FU_TYPES)  target FU class.
- dp_rob_tag  in  ROB_TAG_W  destination ROB tag.
- dp_src1_ready, dp_src2_ready  in  1 each  operand already available (map table/ROB/regfile).
- dp_src1_tag, dp_src2_tag  in  ROB_TAG_W each  producer tag when not ready.
- dp_src1_value, dp_src2_value  in  DATA_W each  value when ready.
- dp_payload  in  PAYLOAD_W  decoded instruction.
- cdb_valid  in  NUM_CDB  per-bus valid.
- cdb_tag  in  NUM_CDB*ROB_TAG_W  flattened tags, bus k at [k*ROB_TAG_W +: ROB_TAG_W].
- cdb_value  in  NUM_CDB*DATA_W  flattened values.
- iss_valid  out  NUM_FU_TYPES  issue request per FU type.
- iss_ready  in  NUM_FU_TYPES  FU accepts.
- iss_rob_tag  out  NUM_FU_TYPES*ROB_TAG_W  per-type flattened.
- iss_src1_value, iss_src2_value  out  NUM_FU_TYPES*DATA_W each.
- iss_payload  out  NUM_FU_TYPES*PAYLOAD_W.
- free_count  out  $clog2(NUM_ENTRIES+1)  number of unoccupied entries.

Behaviour:
- Entry state: valid, fu_type, rob_tag, per-source {rdy, tag, value}, payload, age row (NUM_ENTRIES bits).
- Reset/squash: all entries invalid. iss_valid=0, dp_ready=1, free_count=NUM_ENTRIES the cycle after. Squash and reset take priority over same-cycle dispatch, issue and wakeup.
- dp_ready: combinational, 1 iff any entry is invalid in current state. Entries freed by this cycle's issue are not reusable until the next cycle.
- Dispatch:
  - When dp_valid&dp_ready&(dp_fu_type<NUM_FU_TYPES), write the lowest-index invalid entry at the clock edge.
  - An out-of-range dp_fu_type is dropped with no allocation.
  - dp_valid while full: ignored, no state change.
- Dispatch-time capture: a source with dp_srcN_ready=0 whose tag matches a valid CDB in the same cycle is stored ready with the CDB value.
- Wakeup: each cycle, every valid entry with a not-ready source compares against all valid CDB buses. On a match it sets rdy and latches the value at the edge. If multiple buses match, the lowest bus index wins.
- Eligibility: valid & src1.rdy & src2.rdy, from registered state only. A CDB match this cycle makes the entry eligible next cycle; there is no same-cycle wakeup-to-issue.
- Select: per FU type, pick one eligible entry of that type. iss_* outputs are combinational from registered state.
- Handshake:
  - iss_valid[t]&iss_ready[t] frees the selected entry at the edge.
  - If iss_ready[t]=0, the entry stays and may be re-selected. Selection may change if an older entry becomes eligible; iss_valid does not need to hold its payload stable.
- Simultaneous dispatch and issue in one cycle: both take effect, allocating and freeing different entries.
- Simultaneous issue and CDB match on an issuing entry: impossible by construction, since an issuing entry is fully ready.
- free_count: registered count. Updated +issues-allocations per cycle; never exceeds NUM_ENTRIES or underflows.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- Defined:
  - Selection is oldest-first via an age matrix. On allocation, the entry's age row is set to the mask of currently valid entries.
  - Freed entries clear their column in all rows.
  - The selected entry is the eligible entry with no older eligible entry of the same type.
- Undefined:
  - Age matrix is not built; selection is lowest-index eligible.

Test Plan:
- Reset then dispatch an ALU op (type 0) with src1 value 5 and src2 value 7, both ready. Required: iss_valid[0]=1 on the next cycle with values 5 and 7; iss_ready=1 frees the entry, and free_count returns to NUM_ENTRIES the cycle after.
- Dispatch with src1 not ready on tag 3, then drive cdb_valid[1]=1, tag 3, value 0xABCD. Required: iss_valid asserts the cycle after the CDB cycle with src1=0xABCD.
- Fill all 8 entries with dp_valid held high. Required: dp_ready=0 and a ninth dispatch is ignored; after one issue, dp_ready=1 the following cycle.
- Dispatch with tag 4 not ready while the CDB broadcasts tag 4 in the same cycle. Required: the entry is stored ready and issues the next cycle.
- Hold iss_ready[2]=0 with two ready MULT entries (dispatched order: entry 3 then entry 1), then release. With RS_AGE_SELECT_EN, entry 3 issues first; without it, entry 1 issues first. Each issues exactly once.
- Assert squash with 5 valid entries and a simultaneous dispatch. Required: pool empty next cycle, free_count=8, no iss_valid.

Source files
------------

// File: rtl/rs_pool.sv
// Shared reservation-station pool: entries tagged with an FU type at dispatch, woken by CDB broadcasts,
// one issue per FU type per cycle. Define RS_AGE_SELECT_EN for oldest-first select via an age matrix.
module rs_pool #(
    parameter int NUM_ENTRIES  = 8,
    parameter int NUM_FU_TYPES = 4,
    parameter int NUM_CDB      = 2,
    parameter int ROB_TAG_W    = 5,
    parameter int DATA_W       = 32,
    parameter int PAYLOAD_W    = 64
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash,
    input  logic                                  dp_valid,
    output logic                                  dp_ready,
    input  logic [$clog2(NUM_FU_TYPES)-1:0]       dp_fu_type,
    input  logic [ROB_TAG_W-1:0]                  dp_rob_tag,
    input  logic                                  dp_src1_ready,
    input  logic                                  dp_src2_ready,
    input  logic [ROB_TAG_W-1:0]                  dp_src1_tag,
    input  logic [ROB_TAG_W-1:0]                  dp_src2_tag,
    input  logic [DATA_W-1:0]                     dp_src1_value,
    input  logic [DATA_W-1:0]                     dp_src2_value,
    input  logic [PAYLOAD_W-1:0]                  dp_payload,
    input  logic [NUM_CDB-1:0]                    cdb_valid,
    input  logic [NUM_CDB*ROB_TAG_W-1:0]          cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]             cdb_value,
    output logic [NUM_FU_TYPES-1:0]               iss_valid,
    input  logic [NUM_FU_TYPES-1:0]               iss_ready,
    output logic [NUM_FU_TYPES*ROB_TAG_W-1:0]     iss_rob_tag,
    output logic [NUM_FU_TYPES*DATA_W-1:0]        iss_src1_value,
    output logic [NUM_FU_TYPES*DATA_W-1:0]        iss_src2_value,
    output logic [NUM_FU_TYPES*PAYLOAD_W-1:0]     iss_payload,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]      free_count
);

    localparam int FT_W  = $clog2(NUM_FU_TYPES);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES+1);
    localparam logic [FT_W:0] NFT = (FT_W+1)'(NUM_FU_TYPES);

    // Entry storage
    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [NUM_ENTRIES-1:0] s1_rdy;
    logic [NUM_ENTRIES-1:0] s2_rdy;
    logic [FT_W-1:0]        ent_type [NUM_ENTRIES];
    logic [ROB_TAG_W-1:0]   ent_rob  [NUM_ENTRIES];
    logic [ROB_TAG_W-1:0]   s1_tag   [NUM_ENTRIES];
    logic [ROB_TAG_W-1:0]   s2_tag   [NUM_ENTRIES];
    logic [DATA_W-1:0]      s1_val   [NUM_ENTRIES];
    logic [DATA_W-1:0]      s2_val   [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   ent_pl   [NUM_ENTRIES];

    // Wakeup: per-entry CDB match, lowest bus index wins
    logic [NUM_ENTRIES-1:0] s1_hit;
    logic [NUM_ENTRIES-1:0] s2_hit;
    logic [DATA_W-1:0]      s1_cdb_val [NUM_ENTRIES];
    logic [DATA_W-1:0]      s2_cdb_val [NUM_ENTRIES];

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            s1_hit[i]     = 1'b0;
            s2_hit[i]     = 1'b0;
            s1_cdb_val[i] = '0;
            s2_cdb_val[i] = '0;
            for (int k = NUM_CDB-1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*ROB_TAG_W +: ROB_TAG_W] == s1_tag[i]) begin
                    s1_hit[i]     = 1'b1;
                    s1_cdb_val[i] = cdb_value[k*DATA_W +: DATA_W];
                end
                if (cdb_valid[k] && cdb_tag[k*ROB_TAG_W +: ROB_TAG_W] == s2_tag[i]) begin
                    s2_hit[i]     = 1'b1;
                    s2_cdb_val[i] = cdb_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Dispatch-time capture of a broadcast arriving alongside the dispatch
    logic              dp_s1_rdy_n, dp_s2_rdy_n;
    logic [DATA_W-1:0] dp_s1_val_n, dp_s2_val_n;

    always_comb begin
        dp_s1_rdy_n = dp_src1_ready;
        dp_s2_rdy_n = dp_src2_ready;
        dp_s1_val_n = dp_src1_value;
        dp_s2_val_n = dp_src2_value;
        for (int k = NUM_CDB-1; k >= 0; k--) begin
            if (!dp_src1_ready && cdb_valid[k] && cdb_tag[k*ROB_TAG_W +: ROB_TAG_W] == dp_src1_tag) begin
                dp_s1_rdy_n = 1'b1;
                dp_s1_val_n = cdb_value[k*DATA_W +: DATA_W];
            end
            if (!dp_src2_ready && cdb_valid[k] && cdb_tag[k*ROB_TAG_W +: ROB_TAG_W] == dp_src2_tag) begin
                dp_s2_rdy_n = 1'b1;
                dp_s2_val_n = cdb_value[k*DATA_W +: DATA_W];
            end
        end
    end

    // Allocation looks only at registered occupancy, so same-cycle frees are not reused
    logic [IDX_W-1:0]       alloc_idx;
    logic [NUM_ENTRIES-1:0] alloc_mask;
    logic                   type_ok;
    logic                   alloc;

    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
            if (!ent_valid[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign dp_ready = ~&ent_valid;
    assign type_ok  = {1'b0, dp_fu_type} < NFT;
    assign alloc    = dp_valid & dp_ready & type_ok;

    always_comb begin
        alloc_mask = '0;
        if (alloc) alloc_mask[alloc_idx] = 1'b1;
    end

    // Select: one eligible entry per FU type, from registered state only
    logic [NUM_ENTRIES-1:0] elig;
    logic [IDX_W-1:0]       sel_idx [NUM_FU_TYPES];
    logic [NUM_FU_TYPES-1:0] sel_found;

    assign elig = ent_valid & s1_rdy & s2_rdy;

`ifdef RS_AGE_SELECT_EN
    // age[i][j] set means entry j is older than entry i
    logic [NUM_ENTRIES-1:0] age      [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] type_elig [NUM_FU_TYPES];

    always_comb begin
        for (int t = 0; t < NUM_FU_TYPES; t++) begin
            type_elig[t] = '0;
            sel_idx[t]   = '0;
            sel_found[t] = 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                type_elig[t][i] = elig[i] && (ent_type[i] == FT_W'(t));
            end
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (type_elig[t][i] && !(|(age[i] & type_elig[t]))) begin
                    sel_idx[t]   = IDX_W'(i);
                    sel_found[t] = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int t = 0; t < NUM_FU_TYPES; t++) begin
            sel_idx[t]   = '0;
            sel_found[t] = 1'b0;
            for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
                if (elig[i] && (ent_type[i] == FT_W'(t))) begin
                    sel_idx[t]   = IDX_W'(i);
                    sel_found[t] = 1'b1;
                end
            end
        end
    end
`endif

    // Issue handshake: a transfer happens on a cycle where iss_valid[t] and iss_ready[t] are both high;
    // the selected entry is freed at that edge. iss_* may change between cycles while ready is low.
    logic [NUM_ENTRIES-1:0] free_mask;
    logic [CNT_W-1:0]       n_issue;

    always_comb begin
        iss_valid      = sel_found;
        iss_rob_tag    = '0;
        iss_src1_value = '0;
        iss_src2_value = '0;
        iss_payload    = '0;
        free_mask      = '0;
        n_issue        = '0;
        for (int t = 0; t < NUM_FU_TYPES; t++) begin
            iss_rob_tag[t*ROB_TAG_W +: ROB_TAG_W] = ent_rob[sel_idx[t]];
            iss_src1_value[t*DATA_W +: DATA_W]    = s1_val[sel_idx[t]];
            iss_src2_value[t*DATA_W +: DATA_W]    = s2_val[sel_idx[t]];
            iss_payload[t*PAYLOAD_W +: PAYLOAD_W] = ent_pl[sel_idx[t]];
            if (sel_found[t] && iss_ready[t]) begin
                free_mask[sel_idx[t]] = 1'b1;
                n_issue               = n_issue + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            ent_valid  <= '0;
            free_count <= CNT_W'(NUM_ENTRIES);
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (ent_valid[i] && !s1_rdy[i] && s1_hit[i]) begin
                    s1_rdy[i] <= 1'b1;
                    s1_val[i] <= s1_cdb_val[i];
                end
                if (ent_valid[i] && !s2_rdy[i] && s2_hit[i]) begin
                    s2_rdy[i] <= 1'b1;
                    s2_val[i] <= s2_cdb_val[i];
                end
            end
            if (alloc) begin
                ent_type[alloc_idx] <= dp_fu_type;
                ent_rob[alloc_idx]  <= dp_rob_tag;
                s1_rdy[alloc_idx]   <= dp_s1_rdy_n;
                s2_rdy[alloc_idx]   <= dp_s2_rdy_n;
                s1_tag[alloc_idx]   <= dp_src1_tag;
                s2_tag[alloc_idx]   <= dp_src2_tag;
                s1_val[alloc_idx]   <= dp_s1_val_n;
                s2_val[alloc_idx]   <= dp_s2_val_n;
                ent_pl[alloc_idx]   <= dp_payload;
            end
            ent_valid  <= (ent_valid & ~free_mask) | alloc_mask;
            free_count <= free_count + n_issue - CNT_W'(alloc);
        end
    end

`ifdef RS_AGE_SELECT_EN
    // New row excludes entries freed this same cycle so stale columns never survive
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) age[i] <= age[i] & ~free_mask;
            if (alloc) age[alloc_idx] <= ent_valid & ~free_mask;
        end
    end
`endif

endmodule

// File: tb/tb_rs_pool.sv
// Bench for rs_pool: directed scenarios followed by random traffic, all checked against a
// sequence-numbered entry model evaluated once per cycle.
module tb_rs_pool;
    localparam int N = 8, T = 4, C = 2, RW = 5, DW = 32, PW = 64;

    logic          clock, reset, squash, dp_valid, dp_ready;
    logic [1:0]    dp_fu_type;
    logic [RW-1:0] dp_rob_tag, dp_src1_tag, dp_src2_tag;
    logic          dp_src1_ready, dp_src2_ready;
    logic [DW-1:0] dp_src1_value, dp_src2_value;
    logic [PW-1:0] dp_payload;
    logic [C-1:0]  cdb_valid;
    logic [C*RW-1:0] cdb_tag;
    logic [C*DW-1:0] cdb_value;
    logic [T-1:0]  iss_valid, iss_ready;
    logic [T*RW-1:0] iss_rob_tag;
    logic [T*DW-1:0] iss_src1_value, iss_src2_value;
    logic [T*PW-1:0] iss_payload;
    logic [3:0]    free_count;

    int total = 0;
    int bad   = 0;

    rs_pool dut (
        .clock(clock), .reset(reset), .squash(squash),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_fu_type(dp_fu_type), .dp_rob_tag(dp_rob_tag),
        .dp_src1_ready(dp_src1_ready), .dp_src2_ready(dp_src2_ready),
        .dp_src1_tag(dp_src1_tag), .dp_src2_tag(dp_src2_tag),
        .dp_src1_value(dp_src1_value), .dp_src2_value(dp_src2_value), .dp_payload(dp_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob_tag(iss_rob_tag),
        .iss_src1_value(iss_src1_value), .iss_src2_value(iss_src2_value),
        .iss_payload(iss_payload), .free_count(free_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: seq orders entries by dispatch time (smaller = older)
    typedef struct {
        bit v; int ft; logic [RW-1:0] rob;
        bit r1; logic [RW-1:0] t1; logic [DW-1:0] v1;
        bit r2; logic [RW-1:0] t2; logic [DW-1:0] v2;
        logic [PW-1:0] pl; int seq;
    } ent_t;
    ent_t m[N];
    int seq_ctr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int msel(input int t);
        int s = -1;
        for (int i = 0; i < N; i++) begin
            if (m[i].v && m[i].r1 && m[i].r2 && m[i].ft == t) begin
`ifdef RS_AGE_SELECT_EN
                if (s < 0 || m[i].seq < m[s].seq) s = i;
`else
                if (s < 0) s = i;
`endif
            end
        end
        return s;
    endfunction

    function automatic bit cdb_lookup(input logic [RW-1:0] tag, output logic [DW-1:0] val);
        val = '0;
        for (int k = 0; k < C; k++) begin
            if (cdb_valid[k] && cdb_tag[k*RW +: RW] == tag) begin
                val = cdb_value[k*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Check outputs against the model for the current inputs, then advance one clock
    task automatic cycle();
        ent_t nm[N];
        int nfree = 0;
        int fi = -1;
        int s;
        logic [DW-1:0] cv;
        #2;
        for (int i = 0; i < N; i++) begin
            if (!m[i].v) begin
                nfree++;
                if (fi < 0) fi = i;
            end
        end
        chk("dp_ready", 64'(dp_ready), 64'(nfree > 0));
        chk("free_count", 64'(free_count), 64'(nfree));
        nm = m;
        for (int t = 0; t < T; t++) begin
            s = msel(t);
            chk($sformatf("iss_valid%0d", t), 64'(iss_valid[t]), 64'(s >= 0));
            if (s >= 0) begin
                chk($sformatf("iss_rob%0d", t), 64'(iss_rob_tag[t*RW +: RW]), 64'(m[s].rob));
                chk($sformatf("iss_src1_%0d", t), 64'(iss_src1_value[t*DW +: DW]), 64'(m[s].v1));
                chk($sformatf("iss_src2_%0d", t), 64'(iss_src2_value[t*DW +: DW]), 64'(m[s].v2));
                chk($sformatf("iss_pl%0d", t), iss_payload[t*PW +: PW], m[s].pl);
                if (iss_ready[t]) nm[s].v = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m[i].v && !m[i].r1 && cdb_lookup(m[i].t1, cv)) begin nm[i].r1 = 1'b1; nm[i].v1 = cv; end
            if (m[i].v && !m[i].r2 && cdb_lookup(m[i].t2, cv)) begin nm[i].r2 = 1'b1; nm[i].v2 = cv; end
        end
        if (dp_valid && fi >= 0) begin
            nm[fi].v = 1'b1; nm[fi].ft = int'(dp_fu_type); nm[fi].rob = dp_rob_tag;
            nm[fi].r1 = dp_src1_ready; nm[fi].t1 = dp_src1_tag; nm[fi].v1 = dp_src1_value;
            nm[fi].r2 = dp_src2_ready; nm[fi].t2 = dp_src2_tag; nm[fi].v2 = dp_src2_value;
            if (!dp_src1_ready && cdb_lookup(dp_src1_tag, cv)) begin nm[fi].r1 = 1'b1; nm[fi].v1 = cv; end
            if (!dp_src2_ready && cdb_lookup(dp_src2_tag, cv)) begin nm[fi].r2 = 1'b1; nm[fi].v2 = cv; end
            nm[fi].pl = dp_payload; nm[fi].seq = seq_ctr;
            seq_ctr++;
        end
        if (reset || squash) begin
            for (int i = 0; i < N; i++) nm[i].v = 1'b0;
        end
        @(posedge clock);
        #1;
        m = nm;
    endtask

    task automatic drive_dp(input logic [1:0] ft, input logic [RW-1:0] rob,
                            input logic r1, input logic [RW-1:0] t1, input logic [DW-1:0] v1,
                            input logic r2, input logic [RW-1:0] t2, input logic [DW-1:0] v2,
                            input logic [PW-1:0] pl);
        dp_valid = 1'b1; dp_fu_type = ft; dp_rob_tag = rob;
        dp_src1_ready = r1; dp_src1_tag = t1; dp_src1_value = v1;
        dp_src2_ready = r2; dp_src2_tag = t2; dp_src2_value = v2;
        dp_payload = pl;
    endtask

    task automatic drive_cdb(input int k, input logic [RW-1:0] tag, input logic [DW-1:0] val);
        cdb_valid[k] = 1'b1;
        cdb_tag[k*RW +: RW] = tag;
        cdb_value[k*DW +: DW] = val;
    endtask

    initial begin
        reset = 1'b1; squash = 1'b0; iss_ready = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        drive_dp(2'd0, 5'd0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0, 64'd0);
        dp_valid = 1'b0;
        for (int i = 0; i < N; i++) m[i].v = 1'b0;
        @(posedge clock);
        #1;
        cycle();
        reset = 1'b0;
        #1;
        chk("reset_free_count", 64'(free_count), 64'd8);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_dp_ready", 64'(dp_ready), 64'd1);

        // Ready ALU op issues next cycle with 5 and 7
        drive_dp(2'd0, 5'd1, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7, 64'h1111);
        cycle();
        dp_valid = 1'b0; iss_ready = 4'b1111;
        #1;
        chk("alu_iss_valid", 64'(iss_valid[0]), 64'd1);
        chk("alu_src1", 64'(iss_src1_value[31:0]), 64'd5);
        chk("alu_src2", 64'(iss_src2_value[31:0]), 64'd7);
        chk("alu_free_count", 64'(free_count), 64'd7);
        cycle();
        iss_ready = '0;
        #1;
        chk("alu_freed", 64'(free_count), 64'd8);

        // CDB wakeup on bus 1
        drive_dp(2'd1, 5'd2, 1'b0, 5'd3, 32'd0, 1'b1, 5'd0, 32'd9, 64'h2222);
        cycle();
        dp_valid = 1'b0;
        drive_cdb(1, 5'd3, 32'hABCD);
        #1;
        chk("wake_not_same_cycle", 64'(iss_valid[1]), 64'd0);
        cycle();
        cdb_valid = '0;
        #1;
        chk("wake_iss_valid", 64'(iss_valid[1]), 64'd1);
        chk("wake_src1", 64'(iss_src1_value[63:32]), 64'hABCD);
        iss_ready = 4'b1111;
        cycle();
        iss_ready = '0;

        // Fill the pool, ninth dispatch ignored, one issue reopens it
        for (int i = 0; i < 9; i++) begin
            drive_dp(2'd0, 5'(i), 1'b0, 5'd20, 32'd0, 1'b1, 5'd0, 32'(i), 64'(100 + i));
            if (i == 8) begin
                #1;
                chk("full_dp_ready", 64'(dp_ready), 64'd0);
                chk("full_free_count", 64'(free_count), 64'd0);
            end
            cycle();
        end
        dp_valid = 1'b0;
        drive_cdb(0, 5'd20, 32'h2020);
        cycle();
        cdb_valid = '0; iss_ready = 4'b0001;
        cycle();
        iss_ready = '0;
        #1;
        chk("reopen_dp_ready", 64'(dp_ready), 64'd1);
        chk("reopen_free_count", 64'(free_count), 64'd1);
        iss_ready = 4'b0001;
        for (int i = 0; i < 7; i++) cycle();
        iss_ready = '0;
        #1;
        chk("drain_free_count", 64'(free_count), 64'd8);

        // Same-cycle dispatch capture
        drive_dp(2'd0, 5'd6, 1'b0, 5'd4, 32'd0, 1'b1, 5'd0, 32'd1, 64'h4444);
        drive_cdb(0, 5'd4, 32'h44);
        cycle();
        dp_valid = 1'b0; cdb_valid = '0;
        #1;
        chk("capture_iss_valid", 64'(iss_valid[0]), 64'd1);
        chk("capture_src1", 64'(iss_src1_value[31:0]), 64'h44);
        iss_ready = 4'b0001;
        cycle();
        iss_ready = '0;

        // MULT ordering: entry 3 dispatched before entry 1
        drive_dp(2'd0, 5'd10, 1'b0, 5'd21, 32'd0, 1'b1, 5'd0, 32'd0, 64'h10);
        cycle();
        drive_dp(2'd1, 5'd11, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2, 64'h11);
        cycle();
        drive_dp(2'd0, 5'd12, 1'b0, 5'd21, 32'd0, 1'b1, 5'd0, 32'd0, 64'h12);
        cycle();
        drive_dp(2'd3, 5'd13, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4, 64'h13);
        cycle();
        dp_valid = 1'b0; iss_ready = 4'b1000;
        cycle();
        iss_ready = '0;
        drive_dp(2'd2, 5'd14, 1'b1, 5'd0, 32'd30, 1'b1, 5'd0, 32'd31, 64'hA3);
        cycle();
        dp_valid = 1'b0; iss_ready = 4'b0010;
        cycle();
        iss_ready = '0;
        drive_dp(2'd2, 5'd15, 1'b1, 5'd0, 32'd10, 1'b1, 5'd0, 32'd11, 64'hA1);
        cycle();
        dp_valid = 1'b0;
        cycle();
        cycle();
        #1;
`ifdef RS_AGE_SELECT_EN
        chk("mult_first", iss_payload[2*PW +: PW], 64'hA3);
`else
        chk("mult_first", iss_payload[2*PW +: PW], 64'hA1);
`endif
        iss_ready = 4'b0100;
        cycle();
        #1;
`ifdef RS_AGE_SELECT_EN
        chk("mult_second", iss_payload[2*PW +: PW], 64'hA1);
`else
        chk("mult_second", iss_payload[2*PW +: PW], 64'hA3);
`endif
        cycle();
        #1;
        chk("mult_done", 64'(iss_valid[2]), 64'd0);
        iss_ready = '0;

        // Squash with five valid entries and a simultaneous dispatch
        for (int i = 0; i < 3; i++) begin
            drive_dp(2'd0, 5'(16 + i), 1'b0, 5'd22, 32'd0, 1'b1, 5'd0, 32'd0, 64'(i));
            cycle();
        end
        #1;
        chk("pre_squash_count", 64'(free_count), 64'd3);
        squash = 1'b1;
        drive_dp(2'd1, 5'd20, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd1, 64'h55);
        cycle();
        squash = 1'b0; dp_valid = 1'b0;
        #1;
        chk("squash_free_count", 64'(free_count), 64'd8);
        chk("squash_iss_valid", 64'(iss_valid), 64'd0);
        chk("squash_dp_ready", 64'(dp_ready), 64'd1);
        cycle();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            drive_dp(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                     {$urandom, $urandom});
            dp_valid = 1'($urandom_range(0, 1));
            cdb_valid = '0;
            for (int k = 0; k < C; k++) begin
                if ($urandom_range(0, 1) == 1) drive_cdb(k, 5'($urandom_range(0, 7)), $urandom);
            end
            iss_ready = 4'($urandom_range(0, 15));
            squash = ($urandom_range(0, 60) == 0);
            reset  = ($urandom_range(0, 120) == 0);
            cycle();
        end
        reset = 1'b0; squash = 1'b0; dp_valid = 1'b0; cdb_valid = '0; iss_ready = '0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
